// File: rtl/sub_tx_c.sv
// sub_tx_c: framed serial transmitter (start, LSB-first data, optional parity, stop)
// with a valid/ready word input and fully registered outputs.
module sub_tx_c #(
   parameter int DATA_W     = 8,
   parameter int DIV        = 4,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              testi_clk_c,
   input  logic              testi_rst_c,
   input  logic [DATA_W-1:0] testi_data_c,
   input  logic              testi_valid_c,
   output logic              testo_ready_c,
   output logic              testo_ser_c,
   output logic              testo_busy_c,
   output logic              testo_parity_c,
   output logic              testo_done_c
);
   localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
   localparam int BW = $clog2(DATA_W) + 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d, ser_q, ser_d, ready_q, ready_d;
   logic              busy_q, busy_d, done_q, done_d, tick, last;
   assign tick = div_q == DW'(DIV - 1);
   assign last = bit_q == BW'(DATA_W - 1);
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         div_d = '0;
         if (testi_valid_c && ready_q) begin
            state_d = START;
            shift_d = testi_data_c;
            par_d   = ^testi_data_c;
         end
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            case (state_q)
               START: state_d = DATA;
               DATA: begin
                  shift_d = shift_q >> 1;
                  bit_d   = last ? '0 : bit_q + 1'b1;
                  if (last) state_d = PARITY_EN != 0 ? PAR : STOP;
               end
               PAR: state_d = STOP;
               STOP: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
      end
      // outputs are derived from the next state so the line moves on the same edge as the state
      ser_d   = state_d == START ? 1'b0 :
                state_d == DATA  ? shift_d[0] :
                state_d == PAR   ? par_d ^ 1'(PARITY_ODD) : 1'b1;
      ready_d = state_d == IDLE;
      busy_d  = state_d != IDLE;
   end
   always_ff @(posedge testi_clk_c) begin
      if (testi_rst_c) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         ser_q   <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         ser_q   <= ser_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign testo_ready_c  = ready_q;
   assign testo_ser_c    = ser_q;
   assign testo_busy_c   = busy_q;
   assign testo_parity_c = par_q;
   assign testo_done_c   = done_q;
endmodule
